// File: rtl/fasm_spsram_bist.sv
// March-test initiator for a FASM single-port RAM: write P, read P, write ~P, read ~P.
// Reports first failing address and a saturating-free mismatch count.
module fasm_spsram_bist #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [DW-1:0] seed_i,
    output logic [AW-1:0] mem_adr_o,
    output logic [DW-1:0] mem_dat_o,
    output logic          mem_wre_o,
    output logic          mem_stb_o,
    input  logic [DW-1:0] mem_dat_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          fail_o,
    output logic [AW-1:0] err_adr_o,
    output logic [AW+1:0] err_cnt_o
);

    typedef enum logic [2:0] {
        StIdle, StWr0, StRd0, StWr1, StRd1, StDrain, StDone
    } state_e;

    state_e        state_q;
    logic [DW-1:0] seed_q;
    logic          cmp_vld_q;
    logic [DW-1:0] cmp_exp_q;
    logic [AW-1:0] cmp_adr_q;

    logic [AW-1:0] adr_nxt;
    logic          adr_last;
    logic [DW-1:0] pat_cur;
    logic [DW-1:0] pat_nxt;
    logic          mismatch;

    // mem_adr_o doubles as the march address counter
    assign adr_nxt  = mem_adr_o + AW'(1);
    assign adr_last = &mem_adr_o;
    assign pat_cur  = seed_q + DW'(mem_adr_o);
    assign pat_nxt  = seed_q + DW'(adr_nxt);
    assign mismatch = cmp_vld_q && (mem_dat_i != cmp_exp_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            seed_q    <= '0;
            cmp_vld_q <= 1'b0;
            cmp_exp_q <= '0;
            cmp_adr_q <= '0;
            mem_adr_o <= '0;
            mem_dat_o <= '0;
            mem_wre_o <= 1'b0;
            mem_stb_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            fail_o    <= 1'b0;
            err_adr_o <= '0;
            err_cnt_o <= '0;
        end else begin
            cmp_vld_q <= 1'b0;
            // Compare the word issued one cycle earlier; runs regardless of phase
            if (mismatch) begin
                err_cnt_o <= err_cnt_o + (AW+2)'(1);
                if (!fail_o) err_adr_o <= cmp_adr_q;
                fail_o <= 1'b1;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q   <= StWr0;
                        seed_q    <= seed_i;
                        done_o    <= 1'b0;
                        fail_o    <= 1'b0;
                        err_adr_o <= '0;
                        err_cnt_o <= '0;
                        busy_o    <= 1'b1;
                        mem_stb_o <= 1'b1;
                        mem_wre_o <= 1'b1;
                        mem_adr_o <= '0;
                        mem_dat_o <= seed_i;
                    end
                end
                StWr0: begin
                    mem_adr_o <= adr_nxt;
                    if (adr_last) begin
                        state_q   <= StRd0;
                        mem_wre_o <= 1'b0;
                    end else begin
                        mem_dat_o <= pat_nxt;
                    end
                end
                StRd0: begin
                    cmp_vld_q <= 1'b1;
                    cmp_exp_q <= pat_cur;
                    cmp_adr_q <= mem_adr_o;
                    mem_adr_o <= adr_nxt;
                    if (adr_last) begin
                        state_q   <= StWr1;
                        mem_wre_o <= 1'b1;
                        mem_dat_o <= ~pat_nxt;
                    end
                end
                StWr1: begin
                    mem_adr_o <= adr_nxt;
                    if (adr_last) begin
                        state_q   <= StRd1;
                        mem_wre_o <= 1'b0;
                    end else begin
                        mem_dat_o <= ~pat_nxt;
                    end
                end
                StRd1: begin
                    cmp_vld_q <= 1'b1;
                    cmp_exp_q <= ~pat_cur;
                    cmp_adr_q <= mem_adr_o;
                    mem_adr_o <= adr_nxt;
                    if (adr_last) begin
                        state_q   <= StDrain;
                        mem_stb_o <= 1'b0;
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fasm_spsram_bist.sv
// Bench for fasm_spsram_bist: behavioural RAM with stuck-at faults, reference march model,
// and a scoreboard monitor checking every RAM access and each run's final status.
module tb_fasm_spsram_bist;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 1 << AW;

    logic          clk_i;
    logic          rst_i;
    logic          start_i;
    logic [DW-1:0] seed_i;
    logic [AW-1:0] mem_adr_o;
    logic [DW-1:0] mem_dat_o;
    logic          mem_wre_o;
    logic          mem_stb_o;
    logic [DW-1:0] mem_dat_i;
    logic          busy_o;
    logic          done_o;
    logic          fail_o;
    logic [AW-1:0] err_adr_o;
    logic [AW+1:0] err_cnt_o;

    fasm_spsram_bist #(.AW(AW), .DW(DW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .seed_i    (seed_i),
        .mem_adr_o (mem_adr_o),
        .mem_dat_o (mem_dat_o),
        .mem_wre_o (mem_wre_o),
        .mem_stb_o (mem_stb_o),
        .mem_dat_i (mem_dat_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .fail_o    (fail_o),
        .err_adr_o (err_adr_o),
        .err_cnt_o (err_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // RAM model: address latched on any strobed edge, read data from latched address
    logic [DW-1:0] ram      [NW];
    logic [DW-1:0] and_mask [NW];
    logic [DW-1:0] or_mask  [NW];
    logic [AW-1:0] lat = '0;

    always @(posedge clk_i) begin
        if (mem_stb_o) begin
            lat <= mem_adr_o;
            if (mem_wre_o) ram[mem_adr_o] <= mem_dat_o;
        end
    end
    assign mem_dat_i = (ram[lat] & and_mask[lat]) | or_mask[lat];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int cycles;
        bit fail;
        int adr;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    logic [DW-1:0] cur_seed = '0;

    // Reference: plain march over the faulty memory, independent of cycle timing
    function automatic exp_t ref_model(input logic [DW-1:0] seed);
        exp_t e;
        logic [DW-1:0] stored [NW];
        logic [DW-1:0] want;
        logic [DW-1:0] got;
        e.cycles = 4 * NW + 1;
        e.fail = 0;
        e.adr = 0;
        e.cnt = 0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int a = 0; a < NW; a++) begin
                want = seed + DW'(a);
                if (ph >= 2) want = ~want;
                if (ph % 2 == 0) begin
                    stored[a] = want;
                end else begin
                    got = (stored[a] & and_mask[a]) | or_mask[a];
                    if (got !== want) begin
                        if (!e.fail) e.adr = a;
                        e.fail = 1;
                        e.cnt++;
                    end
                end
            end
        end
        return e;
    endfunction

    // Monitor: checks RAM traffic per access, pops the scoreboard on done rising
    int k = 0;
    int busy_cnt = 0;
    int runs_done = 0;
    bit done_prev = 0;
    int m_a;
    int m_ph;
    logic [DW-1:0] m_want;
    exp_t m_e;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            k = 0;
            busy_cnt = 0;
            done_prev = 0;
        end else begin
            if (busy_o) busy_cnt++;
            if (mem_stb_o) begin
                m_a = k % NW;
                m_ph = k / NW;
                chk("access_phase_range", 64'(m_ph < 4), 64'd1);
                chk("mem_adr", 64'(mem_adr_o), 64'(m_a));
                chk("mem_wre", 64'(mem_wre_o), 64'(m_ph % 2 == 0));
                if (mem_wre_o && m_ph % 2 == 0) begin
                    m_want = cur_seed + DW'(m_a);
                    if (m_ph >= 2) m_want = ~m_want;
                    chk("mem_dat", 64'(mem_dat_o), 64'(m_want));
                end
                k++;
            end
            if (done_o && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("busy_cycles", 64'(busy_cnt), 64'(m_e.cycles));
                    chk("access_count", 64'(k), 64'(4 * NW));
                    chk("fail", 64'(fail_o), 64'(m_e.fail));
                    chk("err_adr", 64'(err_adr_o), 64'(m_e.adr));
                    chk("err_cnt", 64'(err_cnt_o), 64'(m_e.cnt));
                    chk("busy_at_done", 64'(busy_o), 64'd0);
                end
                busy_cnt = 0;
                k = 0;
                runs_done++;
            end
            done_prev = done_o;
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < NW; i++) begin
            and_mask[i] = '1;
            or_mask[i] = '0;
        end
    endtask

    task automatic start_run(input logic [DW-1:0] seed, input bit expect_done);
        if (expect_done) exp_q.push_back(ref_model(seed));
        cur_seed = seed;
        seed_i = seed;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        seed_i = $urandom;
    endtask

    task automatic wait_runs(input int target);
        int n;
        n = 0;
        while (runs_done < target && n < 300) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (runs_done < target) chk("run_timeout", 64'(runs_done), 64'(target));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stb"}, 64'(mem_stb_o), 64'd0);
        chk({tag, "_wre"}, 64'(mem_wre_o), 64'd0);
        chk({tag, "_adr"}, 64'(mem_adr_o), 64'd0);
        chk({tag, "_dat"}, 64'(mem_dat_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_fail"}, 64'(fail_o), 64'd0);
        chk({tag, "_err_adr"}, 64'(err_adr_o), 64'd0);
        chk({tag, "_err_cnt"}, 64'(err_cnt_o), 64'd0);
    endtask

    initial begin
        int target;
        int n;
        int nf;
        int w;
        int b;
        logic [DW-1:0] s;
        rst_i = 1'b0;
        start_i = 1'b0;
        seed_i = '0;
        clear_faults();
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        target = 0;

        // Clean run, seed 0
        start_run(32'h0, 1);
        target++;
        wait_runs(target);
        chk("ram15_after_clean", 64'(ram[15]), 64'hFFFF_FFF0);

        // Stuck-at-0 on word 5 bit 0
        and_mask[5][0] = 1'b0;
        start_run(32'h0, 1);
        target++;
        wait_runs(target);
        chk("stuck_fail", 64'(fail_o), 64'd1);
        chk("stuck_adr", 64'(err_adr_o), 64'd5);
        chk("stuck_cnt", 64'(err_cnt_o), 64'd1);

        // Two faults; start from a failing DONE must clear status at the accepting edge
        clear_faults();
        or_mask[3][31] = 1'b1;
        and_mask[9][0] = 1'b0;
        start_run(32'h0, 1);
        chk("restart_fail_clr", 64'(fail_o), 64'd0);
        chk("restart_adr_clr", 64'(err_adr_o), 64'd0);
        chk("restart_cnt_clr", 64'(err_cnt_o), 64'd0);
        chk("restart_busy", 64'(busy_o), 64'd1);
        chk("restart_done_clr", 64'(done_o), 64'd0);
        target++;
        wait_runs(target);
        chk("two_adr", 64'(err_adr_o), 64'd3);
        chk("two_cnt", 64'(err_cnt_o), 64'd2);

        // Pattern wrap
        clear_faults();
        start_run(32'hFFFF_FFF8, 1);
        target++;
        wait_runs(target);

        // Start pulse while busy is ignored
        start_run(32'h1234_5678, 1);
        repeat (19) @(posedge clk_i);
        #1;
        seed_i = 32'hDEAD_BEEF;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        target++;
        wait_runs(target);

        // Reset during RD0 at address 6, with a fault already recorded at word 2
        and_mask[2][4] = 1'b0;
        start_run(32'h0000_0010, 0);
        n = 0;
        while (!(mem_stb_o && !mem_wre_o && mem_adr_o == 6) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("reached_rd0_adr6", 64'(n < 200), 64'd1);
        chk("fail_before_reset", 64'(fail_o), 64'd1);
        #1;
        rst_i = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        clear_faults();
        @(negedge clk_i);
        start_run(32'h0, 1);
        target++;
        wait_runs(target);

        // start_i held high: back-to-back runs
        s = $urandom;
        exp_q.push_back(ref_model(s));
        exp_q.push_back(ref_model(s));
        cur_seed = s;
        seed_i = s;
        start_i = 1'b1;
        target += 2;
        wait_runs(target);
        start_i = 1'b0;

        // Randomized seeds and stuck-at faults
        for (int r = 0; r < 6; r++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                w = $urandom_range(0, NW - 1);
                b = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 0) and_mask[w][b] = 1'b0;
                else or_mask[w][b] = 1'b1;
            end
            @(negedge clk_i);
            start_run($urandom, 1);
            target++;
            wait_runs(target);
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
